sdram_wb_arbiter: RTL and testbench
===================================

// Module: sdram_wb_arbiter
// PURPOSE
//  Shares the single Wishbone slave port of the SDRAM controller between NUM_MASTERS
//  requesters: CPU instruction bus, CPU data bus and debug/JTAG bus.
//  Round-robin grant, held for the whole cyc (bursts and RMW locks stay atomic).
//  Stall watchdog returns err to the owner if SDRAM never acks.
//  Sits between the wb interconnect master ports and the SDRAM controller in orpsoc_top.
// PARAMETERS
//  NUM_MASTERS  3    number of requesting masters (2..8)
//  AW           32   address width
//  DW           32   data width (sel width = DW/8)
//  TIMEOUT      255  cycles with stb high and no ack/err before the watchdog fires (>=2)
// PORTS
//  wb_clk_i   in   1               system clock
//  wb_rst_i   in   1               asynchronous active-high reset
//  wbm_adr_i  in   NUM_MASTERS*AW  master addresses, master m at [m*AW +: AW]
//  wbm_dat_i  in   NUM_MASTERS*DW  master write data
//  wbm_sel_i  in   NUM_MASTERS*DW/8  byte selects
//  wbm_we_i   in   NUM_MASTERS     write enables
//  wbm_cyc_i  in   NUM_MASTERS     cycle (request) lines
//  wbm_stb_i  in   NUM_MASTERS     strobes
//  wbm_cti_i  in   NUM_MASTERS*3   cycle type ids
//  wbm_bte_i  in   NUM_MASTERS*2   burst type ext
//  wbm_dat_o  out  DW              read data, broadcast to all masters
//  wbm_ack_o  out  NUM_MASTERS     ack, owner only
//  wbm_err_o  out  NUM_MASTERS     err, owner only
//  wbs_adr_o/dat_o/sel_o/we_o/cyc_o/stb_o/cti_o/bte_o  out  widths as above  to SDRAM ctrl
//  wbs_dat_i  in   DW              SDRAM read data
//  wbs_ack_i  in   1               SDRAM ack
//  wbs_err_i  in   1               SDRAM err
//  grant_o    out  NUM_MASTERS     one-hot current owner, debug/perf counters
//  timeout_o  out  1               one-cycle pulse when the watchdog fires
// BEHAVIOUR
//  Reset: state=IDLE; grant_o=0; wbs_cyc_o=wbs_stb_o=wbs_we_o=0; ack/err=0; timeout_o=0.
//    last_owner=NUM_MASTERS-1, so master 0 wins the first tie.
//  FSM IDLE -> GRANT -> (IDLE | ERR):
//  IDLE: if any wbm_cyc_i, pick the first requester after last_owner in circular order.
//    Registered grant: owner's signals reach wbs_* the cycle after it raised cyc.
//    Arbitration latency is 1 cycle.
//  GRANT: wbs_* = owner's inputs combinationally; wbs_cyc_o=owner cyc.
//    wbm_ack_o[owner]=wbs_ack_i and wbm_err_o[owner]=wbs_err_i; non-owners see ack=err=0.
//    Owner cyc low -> IDLE next cycle, last_owner=owner, grant_o=0.
//    Minimum gap of 1 idle cycle between owners.
//    Other masters' cyc/stb are ignored while a grant is held.
//    Bursts (cti 001/010) are never split.
//  Watchdog: 8-bit-min counter, cleared on IDLE, on ack/err, or on stb low.
//    Increments while owner stb=1 and no ack/err.
//    At count==TIMEOUT-1: err_o[owner]=1 for one cycle, timeout_o=1, wbs_cyc/stb forced 0,
//    then state goes to ERR.
//  ERR: wbs_cyc_o=0; wait for owner cyc low -> IDLE with last_owner=owner.
//    Late wbs_ack_i is discarded.
//  Simultaneous ack and timeout threshold: ack wins, no err, counter cleared.
//  Owner releases while others request: IDLE 1 cycle, then round-robin from the next index.
//  Requester drops cyc before being granted: nothing is granted to it.
//  wb_rst_i mid-transfer: all outputs are immediately 0 and the in-flight SDRAM cycle is
//    abandoned; the SDRAM controller is reset by the same wb_rst_i.
//  wbm_dat_o=wbs_dat_i always (unqualified; masters qualify it with ack).
// STRUCTURE
//  Shared include wb_common.vh holds the constants:
//    CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INC=3'b010, CTI_EOB=3'b111, BTE_LINEAR=2'b00.
//    FSM state encodings stay local.
//  One sub-module, wb_rr_picker (N-bit request, last_owner in -> one-hot grant + index out).
//    It is combinational; the FSM, mux and watchdog stay in the top.
// TESTING
//  1: Reset, then only master 1 issues a read at 0x0000_0100.
//    -> grant_o=3'b010 after 1 cycle; wbs_adr_o=0x100.
//    -> ack reaches only wbm_ack_o[1]; grant_o=0 one cycle after cyc drops.
//  2: Masters 0,1,2 hold cyc continuously with single transfers.
//    -> grant order 0,1,2,0,1,2; every owner change has one idle cycle.
//  3: Master 0 runs an 8-beat incrementing burst (cti 010, last 111) while master 2 requests.
//    -> all 8 acks go to master 0 uninterrupted; master 2 is granted after master 0 drops cyc.
//  4: TIMEOUT=16, slave never acks master 1's write.
//    -> the 16th stalled cycle gives wbm_err_o[1]=1 and timeout_o=1 for 1 cycle, wbs_cyc_o=0.
//    -> no further grant until master 1 drops cyc.
//  5: Slave ack coincides with the watchdog threshold -> ack delivered, err_o=0, timeout_o=0.
//  6: Assert wb_rst_i mid-burst of master 2.
//    -> all outputs 0 in the same cycle; after reset, with all requesting, master 0 is first.

Source files
------------

// File: rtl/sdram_wb_arbiter_pkg.sv
// ============================================================================
// Module   : sdram_wb_arbiter_pkg
// Brief    : Shared Wishbone constants and sizing helpers for the SDRAM
//            Wishbone arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package sdram_wb_arbiter_pkg;

    `include "wb_common.vh"

    // The watchdog counter is never narrower than this
    localparam int WDOG_MIN_W = 8;

    // Width of the stall watchdog counter for a given threshold
    function automatic int wdog_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < WDOG_MIN_W) ? WDOG_MIN_W : w;
    endfunction

    // Width of a master index; at least one bit
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sdram_wb_arbiter_rr_picker.sv
// ============================================================================
// Module   : wb_rr_picker
// Brief    : Combinational round-robin picker. Chooses the first requester
//            after last_i in circular order; returns one-hot and index form.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_rr_picker #(
    parameter int N  = 3,
    parameter int IW = 2
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] last_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] idx_o,
    output logic          valid_o
);

    logic [IW-1:0] cand;
    logic          found;

    // Scan from last_i+1 around the ring; the first active request wins
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = 1; k <= N; k++) begin
            cand = IW'((int'(last_i) + k) % N);
            if (!found && req_i[cand]) begin
                found        = 1'b1;
                gnt_o[cand]  = 1'b1;
                idx_o        = cand;
            end
        end
        valid_o = found;
    end

endmodule

`default_nettype wire

// File: rtl/wb_common.vh
`ifndef WB_COMMON_VH
`define WB_COMMON_VH

// Wishbone registered-feedback cycle type identifiers
localparam logic [2:0] CTI_CLASSIC = 3'b000;
localparam logic [2:0] CTI_CONST   = 3'b001;
localparam logic [2:0] CTI_INC     = 3'b010;
localparam logic [2:0] CTI_EOB     = 3'b111;

// Wishbone burst type extension
localparam logic [1:0] BTE_LINEAR  = 2'b00;

`endif

// File: rtl/sdram_wb_arbiter.sv
// ============================================================================
// Module   : sdram_wb_arbiter
// Brief    : Shares the SDRAM controller Wishbone slave port between several
//            masters. Round-robin grant held for the whole cyc, with a stall
//            watchdog that returns err to the owner if the slave never acks.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sdram_wb_arbiter
    import sdram_wb_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int AW          = 32,
    parameter int DW          = 32,
    parameter int TIMEOUT     = 255
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_i,
    // master side
    input  logic [NUM_MASTERS*AW-1:0] wbm_adr_i,
    input  logic [NUM_MASTERS*DW-1:0] wbm_dat_i,
    input  logic [NUM_MASTERS*DW/8-1:0] wbm_sel_i,
    input  logic [NUM_MASTERS-1:0]    wbm_we_i,
    input  logic [NUM_MASTERS-1:0]    wbm_cyc_i,
    input  logic [NUM_MASTERS-1:0]    wbm_stb_i,
    input  logic [NUM_MASTERS*3-1:0]  wbm_cti_i,
    input  logic [NUM_MASTERS*2-1:0]  wbm_bte_i,
    output logic [DW-1:0]             wbm_dat_o,
    output logic [NUM_MASTERS-1:0]    wbm_ack_o,
    output logic [NUM_MASTERS-1:0]    wbm_err_o,
    // SDRAM controller side
    output logic [AW-1:0]             wbs_adr_o,
    output logic [DW-1:0]             wbs_dat_o,
    output logic [DW/8-1:0]           wbs_sel_o,
    output logic                      wbs_we_o,
    output logic                      wbs_cyc_o,
    output logic                      wbs_stb_o,
    output logic [2:0]                wbs_cti_o,
    output logic [1:0]                wbs_bte_o,
    input  logic [DW-1:0]             wbs_dat_i,
    input  logic                      wbs_ack_i,
    input  logic                      wbs_err_i,
    // status
    output logic [NUM_MASTERS-1:0]    grant_o,
    output logic                      timeout_o
);

    localparam int SW  = DW / 8;
    localparam int IW  = idx_width(NUM_MASTERS);
    localparam int WDW = wdog_width(TIMEOUT);
    localparam logic [WDW-1:0] WDOG_LIMIT = WDW'(TIMEOUT - 1);
    localparam logic [IW-1:0]  LAST_INIT  = IW'(NUM_MASTERS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_ERR   = 2'd2
    } arb_state_e;

    arb_state_e             state_q, state_d;
    logic [IW-1:0]          owner_q, owner_d;
    logic [IW-1:0]          last_owner_q, last_owner_d;
    logic [NUM_MASTERS-1:0] grant_q, grant_d;
    logic [WDW-1:0]         wdog_q, wdog_d;

    logic [NUM_MASTERS-1:0] pick_gnt;
    logic [IW-1:0]          pick_idx;
    logic                   pick_valid;

    // owner's bus lines, selected by the one-hot grant
    logic [AW-1:0]          own_adr;
    logic [DW-1:0]          own_dat;
    logic [SW-1:0]          own_sel;
    logic                   own_we;
    logic                   own_cyc;
    logic                   own_stb;
    logic [2:0]             own_cti;
    logic [1:0]             own_bte;
    logic                   stall;

    wb_rr_picker #(
        .N  (NUM_MASTERS),
        .IW (IW)
    ) u_picker (
        .req_i   (wbm_cyc_i),
        .last_i  (last_owner_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    // Select the current owner's request lines
    always_comb begin
        own_adr = '0;
        own_dat = '0;
        own_sel = '0;
        own_we  = 1'b0;
        own_cyc = 1'b0;
        own_stb = 1'b0;
        own_cti = '0;
        own_bte = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (grant_q[m]) begin
                own_adr = wbm_adr_i[m*AW +: AW];
                own_dat = wbm_dat_i[m*DW +: DW];
                own_sel = wbm_sel_i[m*SW +: SW];
                own_we  = wbm_we_i[m];
                own_cyc = wbm_cyc_i[m];
                own_stb = wbm_stb_i[m];
                own_cti = wbm_cti_i[m*3 +: 3];
                own_bte = wbm_bte_i[m*2 +: 2];
            end
        end
    end

    // A strobe that the slave has neither acked nor errored this cycle
    assign stall = own_stb && !wbs_ack_i && !wbs_err_i;

    // Read data is broadcast; masters qualify it with their own ack
    assign wbm_dat_o = wbs_dat_i;
    assign grant_o   = grant_q;

    // Next-state, slave-port mux, response routing and watchdog
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        grant_d      = grant_q;
        wdog_d       = '0;
        wbs_adr_o    = '0;
        wbs_dat_o    = '0;
        wbs_sel_o    = '0;
        wbs_we_o     = 1'b0;
        wbs_cyc_o    = 1'b0;
        wbs_stb_o    = 1'b0;
        wbs_cti_o    = '0;
        wbs_bte_o    = '0;
        wbm_ack_o    = '0;
        wbm_err_o    = '0;
        timeout_o    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d = ST_GRANT;
                    owner_d = pick_idx;
                    grant_d = pick_gnt;
                end
            end

            ST_GRANT: begin
                wbs_adr_o = own_adr;
                wbs_dat_o = own_dat;
                wbs_sel_o = own_sel;
                wbs_we_o  = own_we;
                wbs_cyc_o = own_cyc;
                wbs_stb_o = own_stb;
                wbs_cti_o = own_cti;
                wbs_bte_o = own_bte;
                wbm_ack_o = grant_q & {NUM_MASTERS{wbs_ack_i}};
                wbm_err_o = grant_q & {NUM_MASTERS{wbs_err_i}};
                if (!own_cyc) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    grant_d      = '0;
                end else if (stall) begin
                    if (wdog_q == WDOG_LIMIT) begin
                        // slave hung: abandon the cycle and error the owner
                        wbm_err_o = grant_q;
                        timeout_o = 1'b1;
                        wbs_cyc_o = 1'b0;
                        wbs_stb_o = 1'b0;
                        state_d   = ST_ERR;
                    end else begin
                        wdog_d = wdog_q + WDW'(1);
                    end
                end
            end

            ST_ERR: begin
                // bus stays released and late slave responses are dropped
                if (!own_cyc) begin
                    state_d      = ST_IDLE;
                    last_owner_d = owner_q;
                    grant_d      = '0;
                end
            end

            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // State registers
    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            state_q      <= ST_IDLE;
            owner_q      <= '0;
            last_owner_q <= LAST_INIT;
            grant_q      <= '0;
            wdog_q       <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            grant_q      <= grant_d;
            wdog_q       <= wdog_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_sdram_wb_arbiter.sv
// ============================================================================
// Module   : tb_sdram_wb_arbiter
// Brief    : Directed self-checking bench for sdram_wb_arbiter (3 masters,
//            watchdog threshold 16).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sdram_wb_arbiter;

    localparam int NM = 3;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 16;

    logic              clk;
    logic              rst;
    logic [NM*AW-1:0]  adr;
    logic [NM*DW-1:0]  dat;
    logic [NM*4-1:0]   sel;
    logic [NM-1:0]     we;
    logic [NM-1:0]     cyc;
    logic [NM-1:0]     stb;
    logic [NM*3-1:0]   cti;
    logic [NM*2-1:0]   bte;
    logic [DW-1:0]     m_dat_o;
    logic [NM-1:0]     m_ack;
    logic [NM-1:0]     m_err;
    logic [AW-1:0]     s_adr;
    logic [DW-1:0]     s_dat_o;
    logic [3:0]        s_sel;
    logic              s_we;
    logic              s_cyc;
    logic              s_stb;
    logic [2:0]        s_cti;
    logic [1:0]        s_bte;
    logic [DW-1:0]     s_dat_i;
    logic              s_ack;
    logic              s_err;
    logic [NM-1:0]     grant;
    logic              tmo;

    int checks;
    int errors;

    sdram_wb_arbiter #(
        .NUM_MASTERS (NM),
        .AW          (AW),
        .DW          (DW),
        .TIMEOUT     (TO)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbm_adr_i (adr),
        .wbm_dat_i (dat),
        .wbm_sel_i (sel),
        .wbm_we_i  (we),
        .wbm_cyc_i (cyc),
        .wbm_stb_i (stb),
        .wbm_cti_i (cti),
        .wbm_bte_i (bte),
        .wbm_dat_o (m_dat_o),
        .wbm_ack_o (m_ack),
        .wbm_err_o (m_err),
        .wbs_adr_o (s_adr),
        .wbs_dat_o (s_dat_o),
        .wbs_sel_o (s_sel),
        .wbs_we_o  (s_we),
        .wbs_cyc_o (s_cyc),
        .wbs_stb_o (s_stb),
        .wbs_cti_o (s_cti),
        .wbs_bte_o (s_bte),
        .wbs_dat_i (s_dat_i),
        .wbs_ack_i (s_ack),
        .wbs_err_i (s_err),
        .grant_o   (grant),
        .timeout_o (tmo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // advance to just after the next rising edge (input drive point)
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // move to the falling edge (output sample point)
    task automatic smp();
        @(negedge clk);
    endtask

    task automatic set_m(input int m, input logic c, input logic s, input logic w,
                         input logic [31:0] a, input logic [2:0] t);
        cyc[m]          = c;
        stb[m]          = s;
        we[m]           = w;
        adr[m*AW +: AW] = a;
        cti[m*3 +: 3]   = t;
        dat[m*DW +: DW] = 32'hD000_0000 | a;
    endtask

    task automatic reset_dut();
        rst     = 1'b1;
        adr     = '0;
        dat     = '0;
        sel     = '1;
        we      = '0;
        cyc     = '0;
        stb     = '0;
        cti     = '0;
        bte     = '0;
        s_dat_i = '0;
        s_ack   = 1'b0;
        s_err   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        reset_dut();
        rst = 1'b1;
        smp();
        checks++;
        if (grant !== 3'b000 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL reset_grant: grant=%b timeout=%b required grant=000 timeout=0", grant, tmo);
        end
        checks++;
        if ({s_cyc, s_stb, s_we} !== 3'b000 || m_ack !== 3'b000 || m_err !== 3'b000) begin
            errors++;
            $display("FAIL reset_bus: cyc/stb/we=%b ack=%b err=%b required all 0",
                     {s_cyc, s_stb, s_we}, m_ack, m_err);
        end
        tick();
        rst = 1'b0;
    endtask

    task automatic test_single_read();
        reset_dut();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 3'b000);
        s_dat_i = 32'hCAFE_0001;
        smp();
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("FAIL t1_latency: grant=%b required 000", grant);
        end
        checks++;
        if (m_dat_o !== 32'hCAFE_0001) begin
            errors++;
            $display("FAIL t1_dat_bcast: dat=%h required cafe0001", m_dat_o);
        end
        tick();
        smp();
        checks++;
        if (grant !== 3'b010 || s_adr !== 32'h100 || s_cyc !== 1'b1 || s_stb !== 1'b1) begin
            errors++;
            $display("FAIL t1_grant: grant=%b adr=%h cyc=%b stb=%b required 010 100 1 1",
                     grant, s_adr, s_cyc, s_stb);
        end
        tick();
        s_ack = 1'b1;
        smp();
        checks++;
        if (m_ack !== 3'b010) begin
            errors++;
            $display("FAIL t1_ack: ack=%b required 010", m_ack);
        end
        tick();
        s_ack = 1'b0;
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
        smp();
        checks++;
        if (s_cyc !== 1'b0 || grant !== 3'b010) begin
            errors++;
            $display("FAIL t1_release: cyc=%b grant=%b required 0 010", s_cyc, grant);
        end
        tick();
        smp();
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("FAIL t1_grant_clear: grant=%b required 000", grant);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0] exp;
        reset_dut();
        for (int m = 0; m < NM; m++) set_m(m, 1'b1, 1'b1, 1'b0, 32'h1000 * (m + 1), 3'b000);
        for (int i = 0; i < 6; i++) begin
            exp = 3'b001 << (i % 3);
            tick();
            s_ack = 1'b1;
            smp();
            checks++;
            if (grant !== exp || m_ack !== exp) begin
                errors++;
                $display("FAIL t2_order[%0d]: grant=%b ack=%b required %b", i, grant, m_ack, exp);
            end
            tick();
            s_ack = 1'b0;
            set_m(i % 3, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
            tick();
            set_m(i % 3, 1'b1, 1'b1, 1'b0, 32'h1000 * ((i % 3) + 1), 3'b000);
            smp();
            checks++;
            if (grant !== 3'b000) begin
                errors++;
                $display("FAIL t2_gap[%0d]: grant=%b required 000", i, grant);
            end
        end
        cyc = '0;
        stb = '0;
        tick();
        tick();
    endtask

    task automatic test_burst();
        logic [31:0] a;
        reset_dut();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h200, 3'b010);
        set_m(2, 1'b1, 1'b1, 1'b0, 32'h900, 3'b000);
        for (int b = 0; b < 8; b++) begin
            tick();
            a = 32'h200 + 32'(4 * b);
            set_m(0, 1'b1, 1'b1, 1'b0, a, (b == 7) ? 3'b111 : 3'b010);
            s_ack = 1'b1;
            smp();
            checks++;
            if (m_ack !== 3'b001 || s_adr !== a) begin
                errors++;
                $display("FAIL t3_beat[%0d]: ack=%b adr=%h required 001 %h", b, m_ack, s_adr, a);
            end
        end
        tick();
        s_ack = 1'b0;
        set_m(0, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
        tick();
        smp();
        checks++;
        if (grant !== 3'b000) begin
            errors++;
            $display("FAIL t3_gap: grant=%b required 000", grant);
        end
        tick();
        smp();
        checks++;
        if (grant !== 3'b100 || s_adr !== 32'h900) begin
            errors++;
            $display("FAIL t3_next: grant=%b adr=%h required 100 900", grant, s_adr);
        end
        cyc = '0;
        stb = '0;
        tick();
        tick();
    endtask

    task automatic test_timeout();
        int early;
        reset_dut();
        set_m(1, 1'b1, 1'b1, 1'b1, 32'h300, 3'b000);
        early = 0;
        for (int k = 1; k < TO; k++) begin
            tick();
            smp();
            if (tmo !== 1'b0 || m_err !== 3'b000) early++;
        end
        checks++;
        if (early !== 0) begin
            errors++;
            $display("FAIL t4_early: cycles with err/timeout before threshold=%0d required 0", early);
        end
        tick();
        smp();
        checks++;
        if (m_err !== 3'b010 || tmo !== 1'b1 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
            errors++;
            $display("FAIL t4_fire: err=%b timeout=%b cyc=%b stb=%b required 010 1 0 0",
                     m_err, tmo, s_cyc, s_stb);
        end
        tick();
        s_ack = 1'b1;
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h400, 3'b000);
        smp();
        checks++;
        if (m_err !== 3'b000 || tmo !== 1'b0 || s_cyc !== 1'b0 || m_ack !== 3'b000) begin
            errors++;
            $display("FAIL t4_errstate: err=%b timeout=%b cyc=%b ack=%b required 000 0 0 000",
                     m_err, tmo, s_cyc, m_ack);
        end
        tick();
        tick();
        smp();
        checks++;
        if (grant !== 3'b010) begin
            errors++;
            $display("FAIL t4_hold: grant=%b required 010", grant);
        end
        s_ack = 1'b0;
        tick();
        set_m(1, 1'b0, 1'b0, 1'b0, 32'h0, 3'b000);
        tick();
        tick();
        smp();
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL t4_after: grant=%b required 001", grant);
        end
        cyc = '0;
        stb = '0;
        tick();
        tick();
    endtask

    task automatic test_ack_at_threshold();
        reset_dut();
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h500, 3'b000);
        for (int k = 1; k < TO; k++) tick();
        tick();
        s_ack = 1'b1;
        smp();
        checks++;
        if (m_ack !== 3'b010 || m_err !== 3'b000 || tmo !== 1'b0 || s_cyc !== 1'b1) begin
            errors++;
            $display("FAIL t5_ack_wins: ack=%b err=%b timeout=%b cyc=%b required 010 000 0 1",
                     m_ack, m_err, tmo, s_cyc);
        end
        tick();
        s_ack = 1'b0;
        smp();
        checks++;
        if (tmo !== 1'b0 || s_cyc !== 1'b1) begin
            errors++;
            $display("FAIL t5_cleared: timeout=%b cyc=%b required 0 1", tmo, s_cyc);
        end
        cyc = '0;
        stb = '0;
        tick();
        tick();
    endtask

    task automatic test_reset_mid_burst();
        reset_dut();
        set_m(2, 1'b1, 1'b1, 1'b1, 32'h700, 3'b010);
        tick();
        tick();
        s_ack = 1'b1;
        tick();
        set_m(0, 1'b1, 1'b1, 1'b0, 32'h010, 3'b000);
        set_m(1, 1'b1, 1'b1, 1'b0, 32'h020, 3'b000);
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if (grant !== 3'b000 || s_cyc !== 1'b0 || s_stb !== 1'b0 || s_we !== 1'b0 ||
            m_ack !== 3'b000 || m_err !== 3'b000 || tmo !== 1'b0) begin
            errors++;
            $display("FAIL t6_async: grant=%b cyc=%b stb=%b we=%b ack=%b err=%b to=%b required all 0",
                     grant, s_cyc, s_stb, s_we, m_ack, m_err, tmo);
        end
        s_ack = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        smp();
        checks++;
        if (grant !== 3'b001) begin
            errors++;
            $display("FAIL t6_first: grant=%b required 001", grant);
        end
        cyc = '0;
        stb = '0;
        tick();
        tick();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        test_reset();
        test_single_read();
        test_round_robin();
        test_burst();
        test_timeout();
        test_ack_at_threshold();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
